// File: rtl/dmac_channel_scheduler_if.sv
// Request/grant/status bundle between the DMAC channel scheduler and its surroundings.
// The master modport is the scheduler's view; slave is the peripheral/arbiter/engine side.
interface dmac_channel_scheduler_if #(
  parameter int NUM_CH = 2,
  parameter int CHW    = 1
);
  logic [NUM_CH-1:0] dmac_req;
  logic              bus_grant;
  logic              ch_done;
  logic              ch_error;
  logic [NUM_CH-1:0] irq_clr;
  logic              bus_req;
  logic              ch_start;
  logic [CHW-1:0]    ch_sel;
  logic              ch_hold;
  logic [NUM_CH-1:0] req_ack;
  logic              busy;
  logic [NUM_CH-1:0] irq_status;
  logic [NUM_CH-1:0] err_status;
  logic              irq;

  modport master (
    input  dmac_req, bus_grant, ch_done, ch_error, irq_clr,
    output bus_req, ch_start, ch_sel, ch_hold, req_ack, busy, irq_status, err_status, irq
  );

  modport slave (
    output dmac_req, bus_grant, ch_done, ch_error, irq_clr,
    input  bus_req, ch_start, ch_sel, ch_hold, req_ack, busy, irq_status, err_status, irq
  );
endinterface

// File: rtl/dmac_channel_scheduler.sv
// Round-robin DMA request scheduler: wins AHB ownership, launches one channel at a time,
// waits for done/error, releases the bus and records sticky per-channel status.
module dmac_channel_scheduler #(
  parameter int NUM_CH   = 2,
  parameter int CHW      = 1,
  parameter int GRANT_TO = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  dmac_channel_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_BUS,
    START,
    XFER,
    RELEASE
  } state_t;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [7:0]     TO_LAST = 8'(GRANT_TO - 1);

  state_t            state, state_nx;
  logic [CHW-1:0]    ch_sel_q, ch_sel_nx;
  logic [CHW-1:0]    last_served, last_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [NUM_CH-1:0] irq_status_q, irq_status_nx;
  logic [NUM_CH-1:0] err_status_q, err_status_nx;
  logic [NUM_CH-1:0] req_ack_q;
  logic              bus_req_q, ch_start_q, ch_hold_q, busy_q, irq_q;

  logic [CHW-1:0]    pick_base, pick_idx, cand;
  logic              pick_valid;

  // RELEASE arbitrates with the just-served channel as the pointer so back-to-back
  // services see exactly one bus-free cycle instead of passing through IDLE.
  assign pick_base = (state == RELEASE) ? ch_sel_q : last_served;

  always_comb begin : rr_pick
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = pick_base;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (cand == LAST_CH) ? '0 : cand + CHW'(1);
      if (!pick_valid && bus.dmac_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin : next_state
    state_nx      = state;
    ch_sel_nx     = ch_sel_q;
    last_nx       = last_served;
    cnt_nx        = cnt;
    irq_status_nx = irq_status_q & ~bus.irq_clr;
    err_status_nx = err_status_q & ~bus.irq_clr;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx  = REQ_BUS;
          ch_sel_nx = pick_idx;
          cnt_nx    = '0;
        end
      end
      REQ_BUS: begin
        if (bus.bus_grant) begin
          state_nx = START;
        end else if (cnt == TO_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      START: state_nx = XFER;
      XFER: begin
        if (bus.ch_error) begin
          err_status_nx[ch_sel_q] = 1'b1;
          state_nx                = RELEASE;
        end else if (bus.ch_done) begin
          irq_status_nx[ch_sel_q] = 1'b1;
          state_nx                = RELEASE;
        end
      end
      RELEASE: begin
        last_nx = ch_sel_q;
        if (pick_valid) begin
          state_nx  = REQ_BUS;
          ch_sel_nx = pick_idx;
          cnt_nx    = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch_sel_q     <= '0;
      last_served  <= LAST_CH;
      cnt          <= '0;
      irq_status_q <= '0;
      err_status_q <= '0;
      req_ack_q    <= '0;
      bus_req_q    <= 1'b0;
      ch_start_q   <= 1'b0;
      ch_hold_q    <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state        <= state_nx;
      ch_sel_q     <= ch_sel_nx;
      last_served  <= last_nx;
      cnt          <= cnt_nx;
      irq_status_q <= irq_status_nx;
      err_status_q <= err_status_nx;
      req_ack_q    <= (state_nx == START) ? (NUM_CH'(1) << ch_sel_nx) : '0;
      bus_req_q    <= (state_nx == REQ_BUS) || (state_nx == START) || (state_nx == XFER);
      ch_start_q   <= (state_nx == START);
      ch_hold_q    <= (state_nx == XFER) && !bus.bus_grant;
      busy_q       <= (state_nx != IDLE);
      irq_q        <= (|irq_status_nx) || (|err_status_nx);
    end
  end

  assign bus.bus_req    = bus_req_q;
  assign bus.ch_start   = ch_start_q;
  assign bus.ch_sel     = ch_sel_q;
  assign bus.ch_hold    = ch_hold_q;
  assign bus.req_ack    = req_ack_q;
  assign bus.busy       = busy_q;
  assign bus.irq_status = irq_status_q;
  assign bus.err_status = err_status_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_dmac_channel_scheduler.sv
// Bench for dmac_channel_scheduler: cycle vector table, directed corner sequences and
// randomized transactions against a transaction-level round-robin/status model.
module tb_dmac_channel_scheduler;

  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int NV  = 23;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  dmac_channel_scheduler_if #(.NUM_CH(N), .CHW(2)) bus ();

  dmac_channel_scheduler #(.NUM_CH(N), .CHW(2), .GRANT_TO(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic       grant;
    logic       done;
    logic       err;
    logic [3:0] clr;
    logic       e_bus_req;
    logic       e_start;
    logic [3:0] e_ack;
    logic [1:0] e_sel;
    logic       e_hold;
    logic       e_busy;
    logic [3:0] e_irqs;
    logic [3:0] e_errs;
    logic       e_irq;
  } vec_t;

  vec_t tbl [NV];

  logic [3:0] m_irq, m_err;
  int         m_last;

  function automatic vec_t row(int req, int g, int d, int e, int clr, int br, int st, int ack,
                               int sel, int hold, int busy, int irqs, int errs, int irq);
    vec_t r;
    r.req = 4'(req);  r.grant = 1'(g);  r.done = 1'(d);  r.err = 1'(e);  r.clr = 4'(clr);
    r.e_bus_req = 1'(br);  r.e_start = 1'(st);  r.e_ack = 4'(ack);  r.e_sel = 2'(sel);
    r.e_hold = 1'(hold);  r.e_busy = 1'(busy);  r.e_irqs = 4'(irqs);  r.e_errs = 4'(errs);
    r.e_irq = 1'(irq);
    return r;
  endfunction

  function automatic logic [18:0] obs();
    return {bus.bus_req, bus.ch_start, bus.req_ack, bus.ch_sel, bus.ch_hold, bus.busy,
            bus.irq_status, bus.err_status, bus.irq};
  endfunction

  function automatic logic [18:0] expv(vec_t r);
    return {r.e_bus_req, r.e_start, r.e_ack, r.e_sel, r.e_hold, r.e_busy,
            r.e_irqs, r.e_errs, r.e_irq};
  endfunction

  // Round-robin reference: first requester after the last served one, wrapping.
  function automatic int rr_pick(logic [3:0] rq, int last);
    for (int i = 1; i <= N; i++)
      if (((rq >> ((last + i) % N)) & 4'h1) != 4'h0) return (last + i) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.dmac_req = '0;  bus.bus_grant = 1'b0;  bus.ch_done = 1'b0;
    bus.ch_error = 1'b0;  bus.irq_clr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (bus.ch_start) ok = 1'b1;
    end
  endtask

  task automatic spurious();
    bus.ch_done  = 1'($urandom);
    bus.ch_error = 1'($urandom);
  endtask

  task automatic rtick(input bit ev_irq, input bit ev_err, input int ch);
    bus.irq_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    tick();
    m_irq &= ~bus.irq_clr;
    m_err &= ~bus.irq_clr;
    if (ev_err) m_err |= 4'(1 << ch);
    else if (ev_irq) m_irq |= 4'(1 << ch);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int highs, starts;
    n_chk  = 0;
    n_fail = 0;

    //       req g d e clr | br st ack sel hold busy irqs errs irq
    tbl[0]  = row(1, 0,0,0,0,  1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = row(1, 0,0,0,0,  1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = row(1, 0,0,0,0,  1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = row(1, 1,0,0,0,  1, 1, 1, 0, 0, 1, 0, 0, 0);
    tbl[4]  = row(0, 1,0,0,0,  1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = row(0, 0,0,0,0,  1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = row(0, 0,0,0,0,  1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = row(0, 0,0,0,0,  1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[8]  = row(0, 1,0,0,0,  1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[9]  = row(0, 1,1,0,0,  0, 0, 0, 0, 0, 1, 1, 0, 1);
    tbl[10] = row(0, 0,0,0,0,  0, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[11] = row(0, 0,0,0,1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = row(2, 0,0,0,0,  1, 0, 0, 1, 0, 1, 0, 0, 0);
    tbl[13] = row(2, 1,0,0,0,  1, 1, 2, 1, 0, 1, 0, 0, 0);
    tbl[14] = row(0, 1,0,0,0,  1, 0, 0, 1, 0, 1, 0, 0, 0);
    tbl[15] = row(0, 1,1,1,0,  0, 0, 0, 1, 0, 1, 0, 2, 1);
    tbl[16] = row(0, 0,0,0,0,  0, 0, 0, 1, 0, 0, 0, 2, 1);
    tbl[17] = row(2, 0,0,0,0,  1, 0, 0, 1, 0, 1, 0, 2, 1);
    tbl[18] = row(2, 1,0,0,0,  1, 1, 2, 1, 0, 1, 0, 2, 1);
    tbl[19] = row(0, 1,0,0,0,  1, 0, 0, 1, 0, 1, 0, 2, 1);
    tbl[20] = row(0, 1,0,1,2,  0, 0, 0, 1, 0, 1, 0, 2, 1);
    tbl[21] = row(0, 1,1,1,0,  0, 0, 0, 1, 0, 0, 0, 2, 1);
    tbl[22] = row(0, 0,0,0,2,  0, 0, 0, 1, 0, 0, 0, 0, 0);

    do_reset();
    chk("reset_outputs", 32'(obs()), 32'(0));

    for (int i = 0; i < NV; i++) begin
      bus.dmac_req  = tbl[i].req;
      bus.bus_grant = tbl[i].grant;
      bus.ch_done   = tbl[i].done;
      bus.ch_error  = tbl[i].err;
      bus.irq_clr   = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(expv(tbl[i])));
    end

    // Back-to-back service with both requests held.
    do_reset();
    bus.dmac_req  = 4'h3;
    bus.bus_grant = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_start(ok);
      chk("rr_start_seen", 32'(ok), 32'(1));
      chk("rr_order", 32'(bus.ch_sel), 32'(s % 2));
      tick();
      bus.ch_done = 1'b1;
      if (s == 3) begin
        tick();
        bus.ch_done  = 1'b0;
        bus.dmac_req = '0;
        chk("rr_release_busreq", 32'(bus.bus_req), 32'(0));
      end else begin
        tick();
        bus.ch_done = 1'b0;
        chk("rr_release_busreq", 32'(bus.bus_req), 32'(0));
        tick();
        chk("rr_gap_one_cycle", 32'(bus.bus_req), 32'(1));
      end
    end
    tick();
    chk("rr_irq_status", 32'({bus.irq_status, bus.busy}), 32'({4'h3, 1'b0}));

    // Grant never arrives.
    do_reset();
    bus.dmac_req = 4'h2;
    tick();
    chk("to_busreq_rise", 32'({bus.bus_req, bus.ch_sel}), 32'({1'b1, 2'd1}));
    bus.dmac_req = '0;
    highs  = 1;
    starts = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.bus_req) highs++;
      if (bus.ch_start || (bus.req_ack != '0)) starts++;
    end
    chk("to_busreq_cycles", 32'(highs), 32'(TO));
    chk("to_no_start", 32'(starts), 32'(0));
    chk("to_idle_noflags", 32'({bus.busy, bus.irq_status, bus.err_status, bus.irq}), 32'(0));

    // Reset in the middle of a transfer restores the round-robin pointer.
    do_reset();
    bus.dmac_req  = 4'h1;
    bus.bus_grant = 1'b1;
    wait_start(ok);
    tick();
    bus.ch_done = 1'b1;
    tick();
    bus.ch_done  = 1'b0;
    bus.dmac_req = 4'h3;
    wait_start(ok);
    chk("rst_pre_sel", 32'({ok, bus.ch_sel, bus.irq}), 32'({1'b1, 2'd1, 1'b1}));
    bus.bus_grant = 1'b0;
    tick();
    chk("rst_pre_hold", 32'({bus.ch_hold, bus.bus_req}), 32'({1'b1, 1'b1}));
    rst = 1'b1;
    tick();
    chk("rst_mid_xfer", 32'({bus.bus_req, bus.busy, bus.irq, bus.ch_hold, bus.irq_status,
                             bus.err_status}), 32'(0));
    rst = 1'b0;
    bus.bus_grant = 1'b1;
    wait_start(ok);
    chk("rst_then_ch0", 32'({ok, bus.ch_sel, bus.req_ack}), 32'({1'b1, 2'd0, 4'h1}));

    // Randomized transactions against the reference model.
    do_reset();
    m_last = N - 1;
    m_irq  = '0;
    m_err  = '0;
    for (int t = 0; t < 80; t++) begin
      logic [3:0] rq;
      int exp_ch, d, x, kind;
      rq     = 4'($urandom_range(1, 15));
      exp_ch = rr_pick(rq, m_last);
      bus.dmac_req  = rq;
      bus.bus_grant = 1'b0;
      spurious();
      rtick(1'b0, 1'b0, 0);
      chk("rnd_pick", 32'({bus.bus_req, bus.ch_sel}), 32'({1'b1, 2'(exp_ch)}));
      bus.dmac_req = '0;
      d = $urandom_range(0, 10);
      for (int k = 0; k < d && k < TO; k++) begin
        spurious();
        rtick(1'b0, 1'b0, 0);
      end
      if (d < TO) begin
        bus.bus_grant = 1'b1;
        spurious();
        rtick(1'b0, 1'b0, 0);
        chk("rnd_start", 32'({bus.ch_start, bus.req_ack}), 32'({1'b1, 4'(1 << exp_ch)}));
        x = $urandom_range(1, 4);
        for (int k = 0; k < x; k++) begin
          bus.bus_grant = 1'($urandom);
          bus.ch_done   = 1'b0;
          bus.ch_error  = 1'b0;
          rtick(1'b0, 1'b0, 0);
          chk("rnd_hold", 32'({bus.ch_hold, bus.bus_req}), 32'({!bus.bus_grant, 1'b1}));
        end
        kind = $urandom_range(0, 2);
        bus.bus_grant = 1'($urandom);
        bus.ch_done   = (kind != 1);
        bus.ch_error  = (kind != 0);
        rtick(kind != 1, kind != 0, exp_ch);
        chk("rnd_end_flags", 32'({bus.bus_req, bus.irq_status, bus.err_status, bus.irq}),
            32'({1'b0, m_irq, m_err, (|m_irq) || (|m_err)}));
        m_last = exp_ch;
        spurious();
        rtick(1'b0, 1'b0, 0);
        chk("rnd_idle", 32'({bus.busy, bus.irq_status, bus.err_status}),
            32'({1'b0, m_irq, m_err}));
      end else begin
        chk("rnd_timeout", 32'({bus.bus_req, bus.busy, bus.irq_status, bus.err_status}),
            32'({2'b00, m_irq, m_err}));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
